// File: rtl/wb_lfsr_master.sv
// Wishbone pipelined initiator: writes a seed to the LFSR responder,
// then streams a programmed number of single reads out on valid/ready.
module wb_lfsr_master #(
  parameter int DW      = 8,
  parameter int CW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [DW-1:0] i_seed,
  input  logic [CW-1:0] i_count,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_data,
  output logic          o_data_valid,
  input  logic          i_data_ready,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic          o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_wb_ack
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_REQ = 3'd1;
  localparam logic [2:0] S_WR_ACK = 3'd2;
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_ACK = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [DW-1:0] seed_q;
  logic [CW-1:0] remain;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          more;

  assign tmo_hit = (tmo == TW'(TIMEOUT - 1));
  assign more    = (remain != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      seed_q <= '0;
      remain <= '0;
      tmo    <= '0;
      o_data <= '0;
      o_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            seed_q <= i_seed;
            remain <= i_count;
            o_err  <= 1'b0;
            state  <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!i_wb_stall) begin
            tmo   <= '0;
            state <= S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (i_wb_ack) begin
            state <= more ? S_RD_REQ : S_DONE;
          end else if (tmo_hit) begin
            o_err <= 1'b1;
            state <= S_DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_RD_REQ: begin
          if (!i_wb_stall) begin
            tmo   <= '0;
            state <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (i_wb_ack) begin
            o_data <= i_wb_data;
            if (more) remain <= remain - CW'(1);
            state  <= S_OUT;
          end else if (tmo_hit) begin
            o_err <= 1'b1;
            state <= S_DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_OUT: begin
          if (i_data_ready) begin
            state <= more ? S_RD_REQ : S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus strobes decode straight from state so reset clears them at once
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);
  assign o_data_valid = (state == S_OUT);
  assign o_wb_stb     = (state == S_WR_REQ) ||
                        (state == S_RD_REQ);
  assign o_wb_cyc     = o_wb_stb ||
                        (state == S_WR_ACK) ||
                        (state == S_RD_ACK);
  assign o_wb_we      = (state == S_WR_REQ);
  assign o_wb_addr    = (state == S_RD_REQ);
  assign o_wb_data    = (state == S_WR_REQ) ? seed_q : '0;

endmodule

// File: tb/tb_wb_lfsr_master.sv
// Bench for wb_lfsr_master: behavioural responder, scoreboard queues
// for written seeds and returned read words.
module tb_wb_lfsr_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] count = '0;
  logic       rdy = 1'b1;
  logic       stall = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] rdata = '0;

  logic       o_busy, o_done, o_err, o_data_valid;
  logic [7:0] o_data, o_wb_data;
  logic       o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr;

  wb_lfsr_master #(.DW(8), .CW(8), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_seed(seed), .i_count(count),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_data(o_data), .o_data_valid(o_data_valid),
    .i_data_ready(rdy),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .i_wb_stall(stall),
    .i_wb_data(rdata), .i_wb_ack(ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] word = 8'h5b;
  logic [7:0] held_data = '0;
  int stall_n = 0, scnt = 0, stb_len = 0;
  int hold_n = 0, wait_n = 0, tmo_seen = 0;
  int nwr = 0, nrd = 0, vcnt = 0, done_cnt = 0;
  int drops = 0, overlap = 0;
  int first_stb = -1, first_v = -1, last_v = -1;
  int done_cyc = 0;
  bit acc_pend = 0, acc_we = 0, outst = 0;
  bit no_ack = 0, spur = 0, held = 0;

  always @(negedge clk) begin
    ack   = 1'b0;
    rdata = '0;
    if (acc_pend) begin
      acc_pend = 0;
      outst    = 1;
      wait_n   = 0;
      if (!(no_ack && !acc_we)) begin
        ack = 1'b1;
        if (!acc_we) begin
          word  = {word[6:0],
                   word[7] ^ word[5] ^ word[4] ^ word[3]};
          rdata = word;
          rq.push_back(word);
        end else begin
          rdata = 8'h3c;
        end
      end
    end
    if (spur) begin
      ack   = 1'b1;
      rdata = 8'hee;
      spur  = 0;
    end
    if (outst) begin
      if (!o_wb_cyc) begin
        outst    = 0;
        tmo_seen = wait_n;
        if (!no_ack) drops++;
      end else if (ack) begin
        outst = 0;
      end else begin
        wait_n++;
      end
    end
    if (o_wb_stb && !outst) begin
      stb_len++;
      if (first_stb < 0) first_stb = cyc_n;
      if (scnt < stall_n) begin
        stall = 1'b1;
        scnt++;
      end else begin
        stall    = 1'b0;
        scnt     = 0;
        acc_pend = 1;
        acc_we   = o_wb_we;
        chk("stb_len", stb_len, stall_n + 1);
        stb_len = 0;
        if (o_wb_we) begin
          nwr++;
          chk("wr_addr", o_wb_addr, 0);
          chk("wr_pending", wq.size(), 1);
          if (wq.size() > 0)
            chk("wr_data", o_wb_data, wq.pop_front());
        end else begin
          nrd++;
          chk("rd_addr", o_wb_addr, 1);
          chk("rd_wdata", o_wb_data, 0);
        end
      end
    end else begin
      stall   = 1'b0;
      scnt    = 0;
      stb_len = 0;
    end
    if (o_data_valid && o_wb_stb) overlap++;
    if (o_data_valid) begin
      vcnt++;
      if (first_v < 0) first_v = cyc_n;
      last_v = cyc_n;
      if (held) chk("hold_data", o_data, held_data);
      if (hold_n > 0) begin
        rdy       = 1'b0;
        hold_n--;
        held      = 1;
        held_data = o_data;
      end else begin
        rdy  = 1'b1;
        held = 0;
        chk("rd_q_len", rq.size(), 1);
        if (rq.size() > 0)
          chk("rdata", o_data, rq.pop_front());
      end
    end else begin
      rdy  = 1'b1;
      held = 0;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc_n;
      chk("busy_in_done", o_busy, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int c0 = 0, dstart = 0;

  task automatic run(input logic [7:0] s,
                     input logic [7:0] c);
    tick(1);
    seed  = s;
    count = c;
    start = 1'b1;
    wq.push_back(s);
    c0 = cyc_n;
    first_stb = -1;
    first_v   = -1;
    dstart    = done_cnt;
    tick(1);
    start = 1'b0;
    chk("err_clr", o_err, 0);
    chk("busy_run", o_busy, 1);
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done_cnt == dstart; i++)
      tick(1);
    chk("done_seen", done_cnt - dstart, 1);
  endtask

  int v0, r0, w0;
  bit found;

  initial begin
    tick(3);
    chk("rst_ctl", {o_wb_cyc, o_wb_stb, o_wb_we,
      o_wb_addr, o_busy, o_done, o_err,
      o_data_valid}, 0);
    chk("rst_data", {o_data, o_wb_data}, 0);
    rst = 1'b0;
    tick(2);

    v0 = vcnt; r0 = nrd; w0 = nwr;
    run(8'ha5, 8'd3);
    wait_done(100);
    chk("t1_stb_cyc", first_stb - c0, 1);
    chk("t1_v_first", first_v - c0, 5);
    chk("t1_v_last", last_v - c0, 11);
    chk("t1_done_cyc", done_cyc - c0, 2 + 3 * 3 + 1);
    chk("t1_err", o_err, 0);
    chk("t1_reads", nrd - r0, 3);
    chk("t1_writes", nwr - w0, 1);
    chk("t1_valids", vcnt - v0, 3);
    tick(1);
    chk("t1_idle", {o_busy, o_done}, 0);

    stall_n = 4;
    v0 = vcnt;
    run(8'h3c, 8'd2);
    wait_done(200);
    chk("t2_valids", vcnt - v0, 2);
    chk("t2_err", o_err, 0);
    stall_n = 0;

    hold_n = 6;
    v0 = vcnt;
    run(8'h5a, 8'd2);
    wait_done(200);
    chk("t3_valids", vcnt - v0, 7 + 1);
    chk("t3_overlap", overlap, 0);

    no_ack = 1;
    v0 = vcnt; r0 = nrd;
    run(8'h77, 8'd2);
    wait_done(100);
    chk("t4_tmo", tmo_seen, 15);
    chk("t4_err", o_err, 1);
    chk("t4_valids", vcnt - v0, 0);
    chk("t4_reads", nrd - r0, 1);
    tick(3);
    chk("t4_sticky", o_err, 1);
    no_ack = 0;
    run(8'h11, 8'd1);
    wait_done(100);
    chk("t4b_err", o_err, 0);

    r0 = nrd; w0 = nwr;
    run(8'hc3, 8'd0);
    start = 1'b1;
    seed  = 8'hff;
    tick(1);
    start = 1'b0;
    wait_done(100);
    chk("t5_done_cyc", done_cyc - c0, 3);
    chk("t5_writes", nwr - w0, 1);
    chk("t5_reads", nrd - r0, 0);
    tick(2);
    v0 = vcnt; dstart = done_cnt;
    spur = 1;
    tick(4);
    chk("t5_spur_busy", o_busy, 0);
    chk("t5_spur_done", done_cnt - dstart, 0);
    chk("t5_spur_v", vcnt - v0, 0);

    stall_n = 20;
    v0 = vcnt;
    run(8'h99, 8'd2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (o_wb_stb && !o_wb_we) found = 1;
      else tick(1);
    end
    chk("t6_rd_stb", found, 1);
    rst = 1'b1;
    tick(1);
    chk("t6_rst", {o_wb_cyc, o_wb_stb, o_busy,
      o_data_valid, o_done}, 0);
    rst = 1'b0;
    tick(5);
    chk("t6_no_done", done_cnt - dstart, 0);
    chk("t6_no_v", vcnt - v0, 0);
    stall_n = 0;
    run(8'h42, 8'd2);
    wait_done(100);
    chk("t6_valids", vcnt - v0, 2);
    chk("t6_err", o_err, 0);

    tick(2);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    chk("cyc_mid_drop", drops, 0);
    chk("stb_valid_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
